// File: rtl/alu_drv_pkg.sv
// Shared types and constants for the ALU request driver.
// Holds the FSM state encoding, the registered ALU request payload,
// the ALU opcode constants and the default WAIT timeout.
package alu_drv_pkg;

    localparam int unsigned DATA_W          = 64;
    localparam int unsigned OP_W            = 4;
    localparam int unsigned DEFAULT_TIMEOUT = 16;

    // ALU opcodes
    localparam logic [OP_W-1:0] OP_AND    = 4'b0000;
    localparam logic [OP_W-1:0] OP_OR     = 4'b0001;
    localparam logic [OP_W-1:0] OP_ADD    = 4'b0011;
    localparam logic [OP_W-1:0] OP_POPCNT = 4'b1000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } drv_state_e;

    // Operand/opcode bundle presented to the ALU
    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [OP_W-1:0]   op;
    } alu_req_t;

endpackage

// File: rtl/alu_req_driver.sv
// alu_req_driver: initiator side of the multi-cycle ALU valid_i/valid_o
// interface. Accepts one request at a time from an upstream ready/valid
// channel, pulses alu_valid_i for one cycle, waits for alu_valid_o,
// captures alu_z and returns it with its tag on a ready/valid response
// channel.
//
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   req_valid/req_ready request handshake; req_a, req_b, req_op, req_tag
//   alu_a/alu_b/alu_op  registered operands, stable from accept to next accept
//   alu_valid_i         one-cycle issue pulse to the ALU
//   alu_z/alu_valid_o   ALU result and completion strobe
//   rsp_valid/rsp_ready response handshake; rsp_z, rsp_tag, rsp_err
//
// Build option:
//   ALU_DRV_TIMEOUT_EN  when defined, WAIT is abandoned after TIMEOUT cycles
//                       with rsp_err = 1 and rsp_z = 0; otherwise rsp_err = 0
//                       and WAIT only exits on alu_valid_o.
module alu_req_driver
    import alu_drv_pkg::*;
#(
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    input  logic [OP_W-1:0]   req_op,
    input  logic [TAG_W-1:0]  req_tag,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    output logic              alu_valid_i,
    input  logic [DATA_W-1:0] alu_z,
    input  logic              alu_valid_o,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_z,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic              rsp_err
);

    // A zero timeout would make WAIT meaningless
    if (TIMEOUT == 0) begin : g_timeout_chk
        $error("alu_req_driver: TIMEOUT must be nonzero");
    end

    drv_state_e        state_q, state_d;
    alu_req_t          req_q, req_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [DATA_W-1:0] z_q, z_d;
    logic              req_ready_q, req_ready_d;
    logic              alu_valid_q, alu_valid_d;
    logic              rsp_valid_q, rsp_valid_d;

`ifdef ALU_DRV_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             timeout_hit_c;

    assign timeout_hit_c = (cnt_q == CNT_W'(TIMEOUT - 1));
`endif

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            req_q       <= '0;
            tag_q       <= '0;
            z_q         <= '0;
            req_ready_q <= 1'b1;
            alu_valid_q <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            tag_q       <= tag_d;
            z_q         <= z_d;
            req_ready_q <= req_ready_d;
            alu_valid_q <= alu_valid_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

`ifdef ALU_DRV_TIMEOUT_EN
    // WAIT cycle counter and error flag
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
`endif

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        tag_d   = tag_q;
        z_d     = z_q;
`ifdef ALU_DRV_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    req_d.a  = req_a;
                    req_d.b  = req_b;
                    req_d.op = req_op;
                    tag_d    = req_tag;
                    state_d  = ISSUE;
                end
            end
            // alu_valid_o here may be left over from the previous op; ignore it
            ISSUE: begin
`ifdef ALU_DRV_TIMEOUT_EN
                cnt_d   = '0;
`endif
                state_d = WAIT;
            end
            WAIT: begin
                if (alu_valid_o) begin
                    z_d     = alu_z;
                    state_d = RESP;
`ifdef ALU_DRV_TIMEOUT_EN
                    err_d   = 1'b0;
                end else if (timeout_hit_c) begin
                    z_d     = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
`endif
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        req_ready_d = (state_d == IDLE);
        alu_valid_d = (state_d == ISSUE);
        rsp_valid_d = (state_d == RESP);
    end

    assign req_ready   = req_ready_q;
    assign alu_a       = req_q.a;
    assign alu_b       = req_q.b;
    assign alu_op      = req_q.op;
    assign alu_valid_i = alu_valid_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_z       = z_q;
    assign rsp_tag     = tag_q;
`ifdef ALU_DRV_TIMEOUT_EN
    assign rsp_err     = err_q;
`else
    assign rsp_err     = 1'b0;
`endif

endmodule

// File: tb/tb_alu_req_driver.sv
// Self-checking bench for alu_req_driver with a behavioural multi-cycle ALU.
// The ALU samples operands on the edge where alu_valid_i is high and raises
// a sticky valid_o five cycles later, holding it until the next issue.
module tb_alu_req_driver;
    import alu_drv_pkg::*;

    localparam int unsigned TAG_W   = 4;
    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned LAT_OK  = 7;
    localparam int unsigned LAT_TO  = TIMEOUT + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [DATA_W-1:0] req_a = '0;
    logic [DATA_W-1:0] req_b = '0;
    logic [OP_W-1:0]   req_op = '0;
    logic [TAG_W-1:0]  req_tag = '0;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [OP_W-1:0]   alu_op;
    logic              alu_valid_i;
    logic [DATA_W-1:0] alu_z;
    logic              alu_valid_o;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [DATA_W-1:0] rsp_z;
    logic [TAG_W-1:0]  rsp_tag;
    logic              rsp_err;

    alu_req_driver #(.TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_tag(req_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_valid_i(alu_valid_i),
        .alu_z(alu_z), .alu_valid_o(alu_valid_o),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_z(rsp_z), .rsp_tag(rsp_tag), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DATA_W-1:0] alu_ref(input logic [OP_W-1:0] op,
                                                  input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        case (op)
            OP_AND:    return a & b;
            OP_OR:     return a | b;
            OP_ADD:    return a + b;
            OP_POPCNT: return DATA_W'($countones(a));
            default:   return '0;
        endcase
    endfunction

    // Behavioural ALU
    logic [5:0]        m_pipe = '0;
    logic [DATA_W-1:0] m_pend = '0;
    logic [DATA_W-1:0] m_z = '0;
    logic              m_vo = 1'b0;
    logic              alu_dead = 1'b0;

    always @(posedge clk) begin
        if (alu_valid_i) begin
            m_pend <= alu_ref(alu_op, alu_a, alu_b);
            m_pipe <= 6'b000001;
            m_vo   <= 1'b0;
        end else begin
            m_pipe <= m_pipe << 1;
            if (m_pipe[4] && !alu_dead) begin
                m_vo <= 1'b1;
                m_z  <= m_pend;
            end
        end
    end
    assign alu_z       = m_z;
    assign alu_valid_o = m_vo;

    // Issue pulse monitor
    int n_pulses = 0;
    logic prev_vi = 1'b0;
    logic pulse_wide = 1'b0;
    always @(negedge clk) begin
        if (alu_valid_i) begin
            n_pulses++;
            if (prev_vi) pulse_wide = 1'b1;
        end
        prev_vi = alu_valid_i;
    end

    typedef struct {
        logic [DATA_W-1:0] z;
        logic [TAG_W-1:0]  tag;
        logic              err;
        int                acc_cyc;
    } exp_t;

    exp_t sb_q[$];
    int n_checks = 0;
    int n_pass = 0;
    int n_accepted = 0;
    int last_acc_cyc = 0;
    int last_hs_cyc = 0;

    task automatic check(input string tag, input logic [DATA_W-1:0] got,
                         input logic [DATA_W-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic send(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                        input logic [OP_W-1:0] op, input logic [TAG_W-1:0] tag,
                        input logic [DATA_W-1:0] exp_z, input logic exp_err);
        bit acc = 1'b0;
        exp_t e;
        @(negedge clk);
        req_a = a; req_b = b; req_op = op; req_tag = tag; req_valid = 1'b1;
        for (int i = 0; i < 64 && !acc; i++) begin
            if (req_ready) begin
                @(posedge clk);
                #1;
                acc = 1'b1;
                req_valid = 1'b0;
                n_accepted++;
                last_acc_cyc = cyc;
                e.z = exp_z; e.tag = tag; e.err = exp_err; e.acc_cyc = cyc;
                sb_q.push_back(e);
            end else begin
                @(negedge clk);
            end
        end
        if (!acc) begin
            req_valid = 1'b0;
            check("req_accepted", 64'(acc), 64'(1));
        end
    endtask

    task automatic recv(input int stall, input int exp_lat);
        bit seen = 1'b0;
        exp_t e;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = rsp_valid;
        end
        check("rsp_valid_seen", 64'(seen), 64'(1));
        if (!seen) return;
        if (sb_q.size() == 0) begin
            check("sb_nonempty", 64'(0), 64'(1));
            return;
        end
        e = sb_q.pop_front();
        check("latency", 64'(cyc - e.acc_cyc), 64'(exp_lat));
        check("one_pulse_per_op", 64'(n_pulses), 64'(n_accepted));
        for (int i = 0; i < stall; i++) begin
            check("stall_valid", 64'(rsp_valid), 64'(1));
            check("stall_z", rsp_z, e.z);
            check("stall_tag", 64'(rsp_tag), 64'(e.tag));
            check("stall_req_ready", 64'(req_ready), 64'(0));
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        check("rsp_z", rsp_z, e.z);
        check("rsp_tag", 64'(rsp_tag), 64'(e.tag));
        check("rsp_err", 64'(rsp_err), 64'(e.err));
        @(posedge clk);
        #1;
        last_hs_cyc = cyc;
        rsp_ready = 1'b0;
        @(negedge clk);
        check("post_hs_valid", 64'(rsp_valid), 64'(0));
        check("post_hs_ready", 64'(req_ready), 64'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [OP_W-1:0] ops [4];
        int hs1;
        ops[0] = OP_AND; ops[1] = OP_OR; ops[2] = OP_ADD; ops[3] = OP_POPCNT;

        // Reset held for three cycles
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        check("rst_req_ready", 64'(req_ready), 64'(1));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_alu_valid_i", 64'(alu_valid_i), 64'(0));
        check("rst_rsp_z", rsp_z, 64'(0));
        check("rst_alu_a", alu_a, 64'(0));

        // Single OR
        send(64'hF0, 64'h0F, OP_OR, 4'd3, 64'hFF, 1'b0);
        check("alu_a_held", alu_a, 64'hF0);
        check("alu_op_held", 64'(alu_op), 64'(OP_OR));
        recv(0, LAT_OK);

        // Back-to-back: second request waits for the first handshake and
        // its ISSUE overlaps the ALU's stale valid_o
        fork
            begin
                send(64'd5, 64'd7, OP_ADD, 4'd1, 64'd12, 1'b0);
                send(64'hFFFF, 64'd0, OP_POPCNT, 4'd2, 64'd16, 1'b0);
            end
            begin
                recv(0, LAT_OK);
                hs1 = last_hs_cyc;
                recv(0, LAT_OK);
            end
        join
        check("b2b_accept_after_hs", 64'(last_acc_cyc), 64'(hs1 + 1));

        // Response stall
        send(64'hFF00FF00, 64'h0FF00FF0, OP_AND, 4'd5, 64'h0F000F00, 1'b0);
        recv(10, LAT_OK);

        // Reset during WAIT drops the op
        send(64'd100, 64'd23, OP_ADD, 4'd9, 64'd123, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("midrst_req_ready", 64'(req_ready), 64'(1));
        check("midrst_rsp_valid", 64'(rsp_valid), 64'(0));
        sb_q.delete();
        repeat (8) begin
            @(negedge clk);
            check("midrst_no_rsp", 64'(rsp_valid), 64'(0));
        end
        send(64'd40, 64'd2, OP_ADD, 4'd7, 64'd42, 1'b0);
        recv(0, LAT_OK);

        // Mixed random operations
        for (int i = 0; i < 4; i++) begin
            logic [DATA_W-1:0] a, b;
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            send(a, b, ops[i], TAG_W'(i + 10), alu_ref(ops[i], a, b), 1'b0);
            recv(i, LAT_OK);
        end

`ifdef ALU_DRV_TIMEOUT_EN
        // ALU never answers
        alu_dead = 1'b1;
        send(64'd1, 64'd1, OP_ADD, 4'd6, 64'd0, 1'b1);
        recv(2, LAT_TO);
        alu_dead = 1'b0;
        send(64'd3, 64'd4, OP_ADD, 4'd8, 64'd7, 1'b0);
        recv(0, LAT_OK);
`endif

        check("issue_pulse_single_cycle", 64'(pulse_wide), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
